// File: rtl/imm_encoder_if.sv
// Request/beat bundle for imm_encoder: a valid/ready request side carrying the
// immediate and format code, and a valid/ready beat side carrying the Imm26 field.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_imm;
    logic [2:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_field;
    logic [1:0]  out_hw;
    logic        out_movk;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, in_imm, in_ctrl, out_ready,
        input  in_ready, out_valid, out_field, out_hw, out_movk, out_last, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_ctrl, out_ready,
        output in_ready, out_valid, out_field, out_hw, out_movk, out_last, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs a 64-bit immediate into the ARMv8 Imm26 field, splitting MOVZ constants
// into MOVZ/MOVK beats. Define IMM_ENC_SKIPZERO_EN to emit only nonzero MOVZ chunks.
module imm_encoder #(
    parameter int MAX_BEATS = 4
) (
    input logic          CLK,
    input logic          resetl,
    imm_encoder_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state_q, state_d;
    logic [63:0] imm_q, imm_d;
    logic [25:0] field_q, field_d;
    logic [1:0]  hw_q, hw_d;
    logic        movk_q, movk_d;
    logic        last_q, last_d;
    logic        err_q, err_d;

    logic [63:0] srcImm;
    logic [3:0]  nzMask;
    logic [3:0]  rangeMask;
    logic [3:0]  emitMask;
    logic        movzErr;
    logic [2:0]  firstHit;
    logic [2:0]  nextHit;
    logic [1:0]  beatIdx;
    logic        moreAfter;
    logic [15:0] chunk;

    // Lowest set mask index >= lo, as {found, index}.
    function automatic logic [2:0] findFrom(input logic [3:0] mask, input logic [2:0] lo);
        logic [2:0] hit;
        hit = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && (3'(k) >= lo)) begin
                hit = {1'b1, 2'(k)};
            end
        end
        return hit;
    endfunction

    function automatic logic anyFrom(input logic [3:0] mask, input logic [2:0] lo);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (mask[k] && (3'(k) >= lo)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Chunk selection serves both the first beat (from the live request) and later beats.
    always_comb begin
        srcImm = (state_q == IDLE) ? bus.in_imm : imm_q;
        for (int k = 0; k < 4; k++) begin
            nzMask[k]    = |srcImm[16*k +: 16];
            rangeMask[k] = (k < MAX_BEATS);
        end
        movzErr = |(nzMask & ~rangeMask);
`ifdef IMM_ENC_SKIPZERO_EN
        emitMask = nzMask & rangeMask;
`else
        emitMask = rangeMask;
`endif
        firstHit = findFrom(emitMask, 3'd0);
        nextHit  = findFrom(emitMask, {1'b0, hw_q} + 3'd1);
        if (state_q == IDLE) begin
            beatIdx = firstHit[2] ? firstHit[1:0] : 2'd0;
        end else begin
            beatIdx = nextHit[2] ? nextHit[1:0] : hw_q;
        end
        moreAfter = anyFrom(emitMask, {1'b0, beatIdx} + 3'd1);
        chunk     = srcImm[{beatIdx, 4'b0000} +: 16];
    end

    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        field_d = field_q;
        hw_d    = hw_q;
        movk_d  = movk_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = EMIT;
                    imm_d   = bus.in_imm;
                    hw_d    = 2'd0;
                    movk_d  = 1'b0;
                    last_d  = 1'b1;
                    err_d   = 1'b0;
                    case (bus.in_ctrl)
                        3'b000: begin
                            field_d = {4'b0, bus.in_imm[11:0], 10'b0};
                            err_d   = |bus.in_imm[63:12];
                        end
                        3'b001: begin
                            field_d = {5'b0, bus.in_imm[8:0], 12'b0};
                            err_d   = !((&bus.in_imm[63:8]) || !(|bus.in_imm[63:8]));
                        end
                        3'b010: begin
                            field_d = bus.in_imm[25:0];
                            err_d   = !((&bus.in_imm[63:25]) || !(|bus.in_imm[63:25]));
                        end
                        3'b011: begin
                            field_d = {2'b0, bus.in_imm[18:0], 5'b0};
                            err_d   = !((&bus.in_imm[63:18]) || !(|bus.in_imm[63:18]));
                        end
                        3'b100: begin
                            // Unrepresentable constants collapse to one flagged beat.
                            if (movzErr) begin
                                field_d = {3'b0, 2'd0, bus.in_imm[15:0], 5'b0};
                                err_d   = 1'b1;
                            end else begin
                                hw_d    = beatIdx;
                                field_d = {3'b0, beatIdx, chunk, 5'b0};
                                last_d  = !moreAfter;
                            end
                        end
                        default: begin
                            field_d = '0;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        hw_d    = beatIdx;
                        field_d = {3'b0, beatIdx, chunk, 5'b0};
                        movk_d  = 1'b1;
                        last_d  = !moreAfter;
                        err_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            imm_q   <= '0;
            field_q <= '0;
            hw_q    <= '0;
            movk_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            field_q <= field_d;
            hw_q    <= hw_d;
            movk_q  <= movk_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_field = field_q;
    assign bus.out_hw    = hw_q;
    assign bus.out_movk  = movk_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;
endmodule
